// File: rtl/divider_unsigned_seq.sv
// rtl/divider_unsigned_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
module divider_unsigned_seq #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  DIVU  = 6'b011011,
    parameter logic [5:0]  OUT   = 6'b111111
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [2*WIDTH-1:0]   r_rq;
    logic [WIDTH-1:0]     r_div;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_out;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_div_zero;

    logic [WIDTH:0]       w_t;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_sub;
    logic [2*WIDTH-1:0]   w_rq_step;

    // Partial remainder shifted left plus the next dividend bit; the extra MSB keeps 2*rem+1 exact.
    always_comb begin
        w_t       = {r_rq[2*WIDTH-1:WIDTH], r_rq[WIDTH-1]};
        w_ge      = (w_t >= {1'b0, r_div});
        w_sub     = w_t[WIDTH-1:0] - r_div;
        w_rq_step = w_ge ? {w_sub, r_rq[WIDTH-2:0], 1'b1}
                         : {w_t[WIDTH-1:0], r_rq[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rq       <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_out      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            // Status flags trail the state register by one edge.
            r_busy <= (r_state == S_RUN);
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (Signal == OUT) begin
                        r_out <= r_rq;
                    end
                    if (Signal == DIVU) begin
                        r_div      <= dataB;
                        r_rq       <= {{WIDTH{1'b0}}, dataA};
                        r_cnt      <= '0;
                        r_div_zero <= (dataB == '0);
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_rq  <= w_rq_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (Signal == OUT) begin
                        r_out <= r_rq;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dataOut  = r_out;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule
